// File: rtl/sw_array_sequencer.sv
// Sequences one Smith-Waterman pass: query load, reference stream, pipeline drain, done pulse.
// Optional best-score tracker compiled in with `define SW_SEQ_SCORE_TRACK_EN.
module sw_array_sequencer #(
  parameter int unsigned NUM_PE = 8,
  parameter int unsigned WIDTH  = 10,
  parameter int unsigned LEN_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] ref_len,
  input  logic [1:0]       q_base,
  input  logic             q_valid,
  output logic             q_ready,
  input  logic [1:0]       r_base,
  input  logic             r_valid,
  output logic             r_ready,
  input  logic             pause,
  output logic [1:0]       pe_s,
  output logic             pe_store_s,
  output logic [1:0]       pe_t,
  output logic             pe_init,
  output logic             pe_stall,
  input  logic [WIDTH-1:0] last_v,
  input  logic             last_init,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] best_score,
  output logic [LEN_W-1:0] best_pos
);

  localparam int unsigned CNT_W = $clog2(NUM_PE + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] qcnt_q, qcnt_d, dcnt_q, dcnt_d;
  logic [LEN_W-1:0] rcnt_q, rcnt_d, len_q, len_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      qcnt_q  <= '0;
      dcnt_q  <= '0;
      rcnt_q  <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      qcnt_q  <= qcnt_d;
      dcnt_q  <= dcnt_d;
      rcnt_q  <= rcnt_d;
      len_q   <= len_d;
    end
  end

  // Next state plus PE-facing outputs; a stall is raised whenever no transfer happens.
  always_comb begin
    state_d    = state_q;
    qcnt_d     = qcnt_q;
    dcnt_d     = dcnt_q;
    rcnt_d     = rcnt_q;
    len_d      = len_q;
    q_ready    = 1'b0;
    r_ready    = 1'b0;
    pe_s       = 2'b00;
    pe_store_s = 1'b0;
    pe_t       = 2'b00;
    pe_init    = 1'b0;
    pe_stall   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d   = ref_len;
          qcnt_d  = '0;
          dcnt_d  = '0;
          rcnt_d  = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        pe_store_s = 1'b1;
        pe_s       = q_base;
        q_ready    = !pause;
        pe_stall   = pause | !q_valid;
        if (q_valid && !pause) begin
          qcnt_d = qcnt_q + CNT_W'(1);
          if (qcnt_q == CNT_W'(NUM_PE - 1)) begin
            state_d = (len_q == '0) ? S_DONE : S_RUN;
          end
        end
      end
      S_RUN: begin
        pe_init  = 1'b1;
        pe_t     = r_base;
        r_ready  = !pause;
        pe_stall = pause | !r_valid;
        if (r_valid && !pause) begin
          rcnt_d = rcnt_q + LEN_W'(1);
          // Compare against len-1 so a full-range ref_len never needs rcnt to wrap.
          if (rcnt_q == len_q - LEN_W'(1)) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        pe_stall = pause;
        if (!pause) begin
          dcnt_d = dcnt_q + CNT_W'(1);
          if (dcnt_q == CNT_W'(NUM_PE - 1)) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);

`ifdef SW_SEQ_SCORE_TRACK_EN
  logic [WIDTH-1:0] best_q;
  logic [LEN_W-1:0] pos_q, tcnt_q;

  // Running signed maximum of the last PE's score; strict compare keeps the earliest tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_q <= '0;
      pos_q  <= '0;
      tcnt_q <= '0;
    end else if (state_q == S_IDLE) begin
      if (start) begin
        best_q <= '0;
        pos_q  <= '0;
        tcnt_q <= '0;
      end
    end else if (last_init && !pe_stall) begin
      tcnt_q <= tcnt_q + LEN_W'(1);
      if ($signed(last_v) > $signed(best_q)) begin
        best_q <= last_v;
        pos_q  <= tcnt_q;
      end
    end
  end

  assign best_score = best_q;
  assign best_pos   = pos_q;
`else
  logic unused_track;
  assign unused_track = ^{last_v, last_init};
  assign best_score   = '0;
  assign best_pos     = '0;
`endif

endmodule

// File: tb/tb_sw_array_sequencer.sv
// Scoreboard bench for sw_array_sequencer with NUM_PE=4: query/reference transfers, timing,
// stalls, pause, async reset and (when compiled in) best-score tracking.
module tb_sw_array_sequencer;
  localparam int unsigned NUM_PE = 4;
  localparam int unsigned WIDTH  = 10;
  localparam int unsigned LEN_W  = 16;

  logic             clk, rst_n, start;
  logic [LEN_W-1:0] ref_len;
  logic [1:0]       q_base, r_base, pe_s, pe_t;
  logic             q_valid, q_ready, r_valid, r_ready, pause;
  logic             pe_store_s, pe_init, pe_stall;
  logic [WIDTH-1:0] last_v, best_score;
  logic             last_init, busy, done;
  logic [LEN_W-1:0] best_pos;

  int cmp_cnt = 0;
  int err_cnt = 0;
  logic [1:0] q_exp[$];
  logic [1:0] t_exp[$];
  logic [1:0] chain[NUM_PE];

  sw_array_sequencer #(.NUM_PE(NUM_PE), .WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ref_len(ref_len),
    .q_base(q_base), .q_valid(q_valid), .q_ready(q_ready),
    .r_base(r_base), .r_valid(r_valid), .r_ready(r_ready),
    .pause(pause), .pe_s(pe_s), .pe_store_s(pe_store_s), .pe_t(pe_t),
    .pe_init(pe_init), .pe_stall(pe_stall), .last_v(last_v), .last_init(last_init),
    .busy(busy), .done(done), .best_score(best_score), .best_pos(best_pos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    start = 0; ref_len = '0; q_base = 0; q_valid = 0; r_base = 0; r_valid = 0;
    pause = 0; last_v = '0; last_init = 0;
  endtask

  // One pass; inputs change 1 after posedge, outputs sampled 4 after posedge.
  task automatic run_pass(input string nm, input int n, input int gap_s, input int gap_n,
                          input int pause_s, input int pause_n, input int abort_r,
                          input bit track);
    int qi, ri, done_at, n_store, n_init, exp_done, exp_bs, exp_bp;
    logic [1:0] qseq[NUM_PE];
    logic [1:0] rseq[$];
    int tv[5] = '{0, 5, 9, 9, 3};
    bit in_gap, in_pause;
    qi = 0; ri = 0; done_at = -1; n_store = 0; n_init = 0;
    q_exp.delete(); t_exp.delete(); rseq.delete();
    for (int k = 0; k < NUM_PE; k++) begin
      qseq[k] = 2'(NUM_PE - 1 - k);
      q_exp.push_back(qseq[k]);
      chain[k] = 2'bxx;
    end
    for (int k = 0; k < n; k++) begin
      rseq.push_back(2'(k % 4));
      t_exp.push_back(2'(k % 4));
    end
    exp_done = (n == 0) ? 1 + NUM_PE : 1 + 2 * NUM_PE + n;
    exp_done = exp_done + gap_n + pause_n;
    exp_bs = 0; exp_bp = 0;
`ifdef SW_SEQ_SCORE_TRACK_EN
    if (track) begin exp_bs = 9; exp_bp = 2; end
`endif
    for (int c = 0; c < 80; c++) begin
      @(posedge clk); #1;
      in_gap   = (c >= gap_s) && (c < gap_s + gap_n);
      in_pause = (c >= pause_s) && (c < pause_s + pause_n);
      start    = (c == 0) || (c == 2);
      ref_len  = (c == 0) ? LEN_W'(n) : '1;
      q_valid  = 1;
      q_base   = (qi < NUM_PE) ? qseq[qi] : 2'b00;
      r_valid  = !in_gap;
      r_base   = (ri < n) ? rseq[ri] : 2'b00;
      pause    = in_pause;
      last_init = track && (c >= 1) && (c <= 5);
      last_v    = (track && c >= 1 && c <= 5) ? WIDTH'(tv[c-1]) : '0;
      #3;
      if (c == 0) begin
        cmp_cnt++;
        if (busy !== 1'b0) begin err_cnt++; $display("FAIL %s busy_before_start got %b want 0", nm, busy); end
      end
      if (c == 1) begin
        cmp_cnt++;
        if (busy !== 1'b1) begin err_cnt++; $display("FAIL %s busy_after_start got %b want 1", nm, busy); end
      end
      if (in_gap) begin
        cmp_cnt++;
        if ({pe_stall, r_ready, pe_init} !== 3'b111) begin
          err_cnt++; $display("FAIL %s gap stall/r_ready/init got %b want 111", nm, {pe_stall, r_ready, pe_init});
        end
      end
      if (in_pause) begin
        cmp_cnt++;
        if ({q_ready, r_ready, pe_stall} !== 3'b001) begin
          err_cnt++; $display("FAIL %s pause q_ready/r_ready/stall got %b want 001", nm, {q_ready, r_ready, pe_stall});
        end
      end
      if (pe_store_s === 1'b1 && pe_stall === 1'b0) begin
        cmp_cnt++;
        if (q_exp.size() == 0) begin
          err_cnt++; $display("FAIL %s extra_query_xfer got pe_s=%0d want none", nm, pe_s);
        end else if (pe_s !== q_exp[0] || q_ready !== 1'b1) begin
          err_cnt++; $display("FAIL %s query_xfer got pe_s=%0d q_ready=%b want %0d,1", nm, pe_s, q_ready, q_exp[0]);
        end
        if (q_exp.size() != 0) void'(q_exp.pop_front());
        for (int k = NUM_PE - 1; k > 0; k--) chain[k] = chain[k-1];
        chain[0] = pe_s;
        qi++; n_store++;
      end
      if (pe_init === 1'b1 && pe_stall === 1'b0) begin
        cmp_cnt++;
        if (t_exp.size() == 0) begin
          err_cnt++; $display("FAIL %s extra_ref_xfer got pe_t=%0d want none", nm, pe_t);
        end else if (pe_t !== t_exp[0] || r_ready !== 1'b1) begin
          err_cnt++; $display("FAIL %s ref_xfer got pe_t=%0d r_ready=%b want %0d,1", nm, pe_t, r_ready, t_exp[0]);
        end
        if (t_exp.size() != 0) void'(t_exp.pop_front());
        ri++; n_init++;
      end
      if (abort_r >= 0 && ri == abort_r) return;
      if (done_at >= 0) begin
        cmp_cnt++;
        if ({done, busy} !== 2'b00) begin
          err_cnt++; $display("FAIL %s after_done done/busy got %b want 00", nm, {done, busy});
        end
        break;
      end
      if (done === 1'b1) begin
        done_at = c;
        cmp_cnt++;
        if (c != exp_done) begin err_cnt++; $display("FAIL %s done_cycle got %0d want %0d", nm, c, exp_done); end
        cmp_cnt++;
        if (n_store != NUM_PE || n_init != n) begin
          err_cnt++; $display("FAIL %s xfer_counts got store=%0d init=%0d want %0d,%0d", nm, n_store, n_init, NUM_PE, n);
        end
        cmp_cnt++;
        if (best_score !== WIDTH'(exp_bs) || best_pos !== LEN_W'(exp_bp)) begin
          err_cnt++; $display("FAIL %s best got %0d@%0d want %0d@%0d", nm, best_score, best_pos, exp_bs, exp_bp);
        end
      end
    end
    idle_inputs();
    cmp_cnt++;
    if (done_at < 0) begin err_cnt++; $display("FAIL %s done_timeout got none want cycle %0d", nm, exp_done); end
    for (int k = 0; k < NUM_PE; k++) begin
      cmp_cnt++;
      if (chain[k] !== 2'(k)) begin err_cnt++; $display("FAIL %s pe%0d_query got %0d want %0d", nm, k, chain[k], k); end
    end
  endtask

  task automatic check_all_zero(input string nm);
    cmp_cnt++;
    if ({q_ready, r_ready, pe_stall, pe_s, pe_store_s, pe_t, pe_init, busy, done} !== 11'b0 ||
        best_score !== '0 || best_pos !== '0) begin
      err_cnt++;
      $display("FAIL %s outputs got qr=%b rr=%b st=%b s=%0d ss=%b t=%0d in=%b busy=%b done=%b bs=%0d bp=%0d want all 0",
               nm, q_ready, r_ready, pe_stall, pe_s, pe_store_s, pe_t, pe_init, busy, done, best_score, best_pos);
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle_inputs();
    #2 check_all_zero("reset");
    q_valid = 1; r_valid = 1; pause = 1; start = 1;
    #1 check_all_zero("reset_inputs_high");
    idle_inputs();
    @(negedge clk); rst_n = 1;
  endtask

  task automatic test_nominal();
    run_pass("nominal", 6, -10, 0, -10, 0, -1, 0);
  endtask

  task automatic test_zero_len();
    run_pass("zero_len", 0, -10, 0, -10, 0, -1, 0);
  endtask

  task automatic test_src_gap();
    run_pass("src_gap", 6, 7, 2, -10, 0, -1, 0);
  endtask

  task automatic test_pause_drain();
    run_pass("pause_drain", 6, -10, 0, 12, 3, -1, 0);
  endtask

  task automatic test_async_reset();
    run_pass("abort", 6, -10, 0, -10, 0, 2, 0);
    @(posedge clk); #2;
    rst_n = 0;
    #1 check_all_zero("async_reset");
    idle_inputs();
    @(negedge clk); rst_n = 1;
    run_pass("post_reset", 1, -10, 0, -10, 0, -1, 0);
  endtask

  task automatic test_tracking();
    run_pass("tracking", 1, -10, 0, -10, 0, -1, 1);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_zero_len();
    test_src_gap();
    test_pause_drain();
    test_async_reset();
    test_tracking();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule

// File: doc/sw_array_sequencer.md
# sw_array_sequencer

Sequences one pass of the Smith-Waterman systolic PE chain. The block shifts NUM_PE query bases into the chain's query shift path (S/store_S), then streams ref_len reference bases with the init flag raised (T/init). It then drains the pipeline and pulses done. It sits between the host-side base FIFOs and PE 0, and owns the chain-wide stall.

## Interface

- NUM_PE, 8: number of PEs in the chain; query bases per pass.
- WIDTH, 10: score width; must match the PE score width.
- LEN_W, 16: width of ref_len and the reference position counter.

Reset is asynchronous and active-low: rst_n asserts asynchronously and releases synchronously to clk.

- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a pass; sampled only in IDLE.
- ref_len  in  LEN_W  number of reference bases; latched on start.
- q_base  in  2  query base stream.
- q_valid  in  1  query stream valid.
- q_ready  out  1  query stream ready.
- r_base  in  2  reference base stream.
- r_valid  in  1  reference stream valid.
- r_ready  out  1  reference stream ready.
- pause  in  1  downstream backpressure; freezes the chain.
- pe_s  out  2  to PE 0 S_in.
- pe_store_s  out  1  to PE 0 store_S_in.
- pe_t  out  2  to PE 0 T_in.
- pe_init  out  1  to PE 0 init_in.
- pe_stall  out  1  chain-wide stall.
- last_v  in  WIDTH  V_out of PE NUM_PE-1; used only with tracking enabled.
- last_init  in  1  init_out of PE NUM_PE-1; used only with tracking enabled.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at end of pass.
- best_score  out  WIDTH  signed maximum score; present only with tracking enabled.
- best_pos  out  LEN_W  reference index of best_score; present only with tracking enabled.

## Operation

- States: IDLE, LOAD, RUN, DRAIN, DONE. The state is registered. PE-facing outputs are combinational from state and handshakes.
- IDLE, on start: latch ref_len, clear counters and tracker, go to LOAD.
- LOAD outputs:
  - pe_store_s=1, pe_s=q_base.
  - q_ready=!pause.
  - pe_stall=pause | !q_valid.
- LOAD counting: each accept (q_valid & q_ready) increments qcnt. After the NUM_PE-th accept, go to RUN, or to DONE if ref_len==0.
- Query ordering: the base accepted k-th ends in PE NUM_PE-1-k. The host supplies the query last-base-first.
- RUN outputs:
  - pe_init=1, pe_t=r_base.
  - r_ready=!pause.
  - pe_stall=pause | !r_valid.
- RUN counting: each accept increments rcnt. At rcnt==ref_len go to DRAIN.
- DRAIN: pe_init=0, pe_t=0, pe_stall=pause. Runs NUM_PE unstalled cycles (dcnt), then goes to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Outside LOAD/RUN/DRAIN, all PE-facing outputs and readies are 0.
- start while busy is ignored.
- Counter widths:
  - qcnt and dcnt: clog2(NUM_PE+1).
  - rcnt: LEN_W.
  - Counters never wrap; ref_len = 2^LEN_W-1 is legal.
- rst_n low in any state returns the block to IDLE. Counters, busy, done and the tracker clear to 0. The PE chain is reset separately.

## Timing

- Reset values: every output is 0, including q_ready, r_ready, pe_stall, busy, done, best_score and best_pos.
- Latency from start:
  - busy rises the cycle after start is sampled.
  - LOAD takes exactly NUM_PE cycles with no stalls or pause.
  - Total from start to done: 1 + NUM_PE + ref_len + NUM_PE + 1 cycles, not counting stalled cycles.
- Handshake: readies never depend on valid. pe_stall is asserted in every cycle in which no transfer occurs in LOAD/RUN.
- Simultaneous pause and valid: no transfer, stall asserted, state and counters frozen.
- A DRAIN cycle counts only when pause=0.

## Configuration

- SW_SEQ_SCORE_TRACK_EN defined: score tracking is compiled in.
  - In any cycle with last_init=1 and pe_stall=0, if signed last_v > best_score, update best_score=last_v and best_pos=tcnt.
  - tcnt is a LEN_W count of such cycles since start.
  - Ties keep the earlier position.
  - best_score and best_pos are valid from done until the next start.
- SW_SEQ_SCORE_TRACK_EN undefined: the tracker is removed, best_score and best_pos are tied to 0, and last_v/last_init are unused.

## Test plan

All scenarios use NUM_PE=4.

- Nominal pass: start, ref_len=6, query fed 3,2,1,0 and reference A,C,G,T,A,C, all valid, pause=0 -> pe_store_s high 4 cycles, pe_init high 6 cycles, DRAIN 4 cycles, done 16 cycles after start; PE k holds query base k.
- Zero-length reference: ref_len=0 -> LOAD of 4 cycles, then DONE; pe_init never rises, done at cycle 6.
- Source gaps: r_valid low for 2 cycles mid-RUN -> pe_stall high and r_ready high in exactly those cycles, rcnt frozen, done delayed by 2 cycles.
- Pause: pause high for 3 cycles during DRAIN -> q_ready=r_ready=0, pe_stall high, dcnt frozen, done delayed by 3 cycles.
- Async reset mid-RUN: rst_n low after 2 reference accepts -> all outputs 0 immediately; after release, start with ref_len=1 completes a clean pass of 11 cycles.
- Tracking, with SW_SEQ_SCORE_TRACK_EN defined: last_v sequence 0,5,9,9,3 with last_init high -> best_score=9, best_pos=2.
